program_sequencer: RTL and testbench
====================================

# program_sequencer

Fetch-stage program sequencer for the 8-bit microprocessor. It generates the program-memory address each cycle, so program memory returns `next_instr` to the instruction decoder, and it consumes the decoder's `jmp`, `jmp_nz` and `ir_nibble` outputs plus the ALU zero flag. Beyond the basic PC it provides a fetch stall, halt detection on a jump-to-self, a retired-fetch counter and a 4-entry taken-branch trace buffer for debug.

## Interface
- `PC_W`, default 8: program counter / program-memory address width.
- `TRACE_DEPTH`, default 4: taken-branch trace entries (power of two, fixed at 4 for this design).
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `jmp` input 1: unconditional jump, from the decoder.
- `jmp_nz` input 1: conditional jump, from the decoder.
- `jmp_addr` input 4: jump target low nibble; the decoder's `ir_nibble`.
- `dont_jmp` input 1: ALU zero flag; when 1, `jmp_nz` is not taken.
- `hold` input 1: fetch stall request.
- `pm_addr` output PC_W: combinational program-memory address.
- `pc` output PC_W: registered address of the instruction currently in the decoder's IR.
- `halted` output 1: high in HALT state.
- `fetch_count` output 16: fetches advanced since reset; wraps.
- `trace_sel` input 2: trace entry select, 0 = newest.
- `trace_src` output PC_W: branch source PC of the selected entry.
- `trace_dst` output PC_W: branch target of the selected entry.
- `trace_valid` output 1: selected entry has been written since reset.

## Operation
- Target: `tgt = {pc[PC_W-1:4], jmp_addr}`. Jumps stay within the current 16-word page.
- Taken: `take = jmp | (jmp_nz & ~dont_jmp)`. If `jmp` and `jmp_nz` are both asserted, treat the jump as unconditional.
- FSM states (`seq_state_t`): RUN, STALL, HALT.
- **RUN**, in priority order:
  - `hold` → `pm_addr = pc`; next state STALL. The jump is not evaluated; the same instruction is refetched and re-decoded.
  - `take & tgt == pc` → `pm_addr = pc`; next state HALT; no trace write.
  - `take` → `pm_addr = tgt`; write trace entry {pc, tgt}.
  - Otherwise → `pm_addr = pc + 1`. The address wraps from 0xFF to 0x00.
- **STALL**:
  - While `hold` is high: `pm_addr = pc`.
  - When `hold` is low: behave exactly as RUN for that cycle.
- **HALT**: `pm_addr = pc`. Ignores `hold`, `jmp` and `jmp_nz`. Only `reset` exits this state.
- `pc <= pm_addr` every cycle.
- `fetch_count` increments on each cycle where `pm_addr != pc` in RUN, or in STALL with `hold` low.
- Trace buffer:
  - Circular; the write pointer wraps 3→0.
  - A fill counter saturates at 4.
  - `trace_valid = (trace_sel < fill)`.
  - The selected entry is the one at `wptr-1-trace_sel`, mod 4.
  - Read path is combinational.
  - Write and read in the same cycle: the read returns the pre-write contents.

## Timing
- Reset (asynchronous assert, release synchronized by the system):
  - `pc = 0`, state RUN, `fetch_count = 0`, fill = 0, `wptr = 0`, all entries 0.
  - While `reset` is high: `pm_addr = 0`, `halted = 0`, `trace_valid = 0`.
- Cycle after release: `pm_addr = 1` (sequential).
- `pm_addr` is combinational from `pc`, the state and the inputs in the same cycle. Zero cycles from `jmp` to `pm_addr`.
- A jump asserted in cycle t puts the target in `pc` at t+1. The decoder sees the target instruction at t+1.
- `halted` rises the cycle after the jump-to-self is detected.
- Reset mid-stall or in HALT returns to RUN at `pc = 0` immediately.

## Structure
- Shared package `defs`: `seq_state_t` {RUN, STALL, HALT}, `PC_W`, `TRACE_DEPTH`.
- Sub-module `branch_trace_buffer`: register file, write pointer, fill counter and select logic, with ports `clk`, `reset`, `wr_en`, `wr_src`, `wr_dst`, `sel`, `rd_src`, `rd_dst`, `rd_valid`.
- FSM, PC register, next-address mux and counter live in the top level.

## Test plan
- Reset release, no jumps, 300 cycles:
  - `pm_addr` counts 0,1,2…
  - wraps 0xFF→0x00.
  - `fetch_count` = 300.
- `pc = 0x37` with `jmp=1`, `jmp_addr=0xA`:
  - `pm_addr = 0x3A` in the same cycle.
  - `pc = 0x3A` next cycle.
  - trace entry 0 = {0x37, 0x3A}, `trace_valid` = 1.
- `pc = 0x20` with `jmp_nz=1`:
  - `dont_jmp=1` → `pm_addr = 0x21`.
  - repeat with `dont_jmp=0` → `pm_addr = 0x2…` target.
- `pc = 0x10` with `hold` high for 3 cycles and `jmp` asserted:
  - `pm_addr` stays 0x10.
  - no trace write.
  - `fetch_count` frozen.
  - the jump is taken in the first cycle after `hold` drops.
- `pc = 0x45`, `jmp=1`, `jmp_addr=5`:
  - `halted = 1` next cycle.
  - `pm_addr` is stuck at 0x45 despite further jumps.
  - asynchronous `reset` → `pc = 0`, `halted = 0`.
- Six taken branches:
  - fill saturates at 4.
  - `trace_sel = 0..3` return the last four, newest first.
  - after reset, `trace_valid = 0` for all `trace_sel`.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the fetch-stage program sequencer.
package defs;
  localparam int unsigned PC_W        = 8;
  localparam int unsigned TRACE_DEPTH = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } seq_state_t;
endpackage

// File: rtl/program_sequencer_trace.sv
// Circular taken-branch trace buffer; newest entry is selected by sel = 0.
module branch_trace_buffer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [PC_W-1:0]          wr_src,
  input  logic [PC_W-1:0]          wr_dst,
  input  logic [$clog2(DEPTH)-1:0] sel,
  output logic [PC_W-1:0]          rd_src,
  output logic [PC_W-1:0]          rd_dst,
  output logic                     rd_valid
);
  import defs::*;

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PC_W-1:0] r_src [DEPTH];
  logic [PC_W-1:0] r_dst [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW:0]     r_fill;
  logic [PW-1:0]   w_rd_idx;

  // Read is purely combinational from the registered state, so a same-cycle
  // write is not visible until the following cycle.
  assign w_rd_idx = r_wptr - PW'(1) - sel;
  assign rd_src   = r_src[w_rd_idx];
  assign rd_dst   = r_dst[w_rd_idx];
  assign rd_valid = ({1'b0, sel} < r_fill);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_fill <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_src[i] <= '0;
        r_dst[i] <= '0;
      end
    end else if (wr_en) begin
      r_src[r_wptr] <= wr_src;
      r_dst[r_wptr] <= wr_dst;
      r_wptr        <= r_wptr + PW'(1);
      if (r_fill != (PW+1)'(DEPTH)) r_fill <= r_fill + (PW+1)'(1);
    end
  end
endmodule

// File: rtl/program_sequencer.sv
// Fetch-stage program sequencer: next-address mux, PC, stall/halt FSM,
// retired-fetch counter and taken-branch trace.
module program_sequencer #(
  parameter int unsigned PC_W        = defs::PC_W,
  parameter int unsigned TRACE_DEPTH = defs::TRACE_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           jmp,
  input  logic                           jmp_nz,
  input  logic [3:0]                     jmp_addr,
  input  logic                           dont_jmp,
  input  logic                           hold,
  output logic [PC_W-1:0]                pm_addr,
  output logic [PC_W-1:0]                pc,
  output logic                           halted,
  output logic [15:0]                    fetch_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_sel,
  output logic [PC_W-1:0]                trace_src,
  output logic [PC_W-1:0]                trace_dst,
  output logic                           trace_valid
);
  import defs::*;

  seq_state_t      r_state;
  seq_state_t      w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_tgt;
  logic [PC_W-1:0] w_pm_addr;
  logic [15:0]     r_fetch_count;
  logic            w_take;
  logic            w_trace_wr;
  logic            w_adv;

  assign w_tgt  = {r_pc[PC_W-1:4], jmp_addr};
  assign w_take = jmp | (jmp_nz & ~dont_jmp);

  // STALL with hold low takes the RUN path, so both share the default arm.
  always_comb begin
    w_pm_addr   = r_pc + PC_W'(1);
    w_state_nxt = RUN;
    w_trace_wr  = 1'b0;
    case (r_state)
      HALT: begin
        w_pm_addr   = r_pc;
        w_state_nxt = HALT;
      end
      default: begin
        if (hold) begin
          w_pm_addr   = r_pc;
          w_state_nxt = STALL;
        end else if (w_take && (w_tgt == r_pc)) begin
          w_pm_addr   = r_pc;
          w_state_nxt = HALT;
        end else if (w_take) begin
          w_pm_addr  = w_tgt;
          w_trace_wr = 1'b1;
        end
      end
    endcase
    if (reset) w_pm_addr = '0;
  end

  assign w_adv = (w_pm_addr != r_pc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= '0;
      r_state       <= RUN;
      r_fetch_count <= '0;
    end else begin
      r_pc    <= w_pm_addr;
      r_state <= w_state_nxt;
      if (w_adv) r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign pm_addr     = w_pm_addr;
  assign pc          = r_pc;
  assign halted      = (r_state == HALT);
  assign fetch_count = r_fetch_count;

  branch_trace_buffer #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (w_trace_wr),
    .wr_src   (r_pc),
    .wr_dst   (w_tgt),
    .sel      (trace_sel),
    .rd_src   (trace_src),
    .rd_dst   (trace_dst),
    .rd_valid (trace_valid)
  );
endmodule

// File: tb/tb_program_sequencer.sv
// Directed scoreboard bench for program_sequencer.
module tb_program_sequencer;
  logic        clk;
  logic        reset;
  logic        jmp;
  logic        jmp_nz;
  logic [3:0]  jmp_addr;
  logic        dont_jmp;
  logic        hold;
  logic [7:0]  pm_addr;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] fetch_count;
  logic [1:0]  trace_sel;
  logic [7:0]  trace_src;
  logic [7:0]  trace_dst;
  logic        trace_valid;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb[$];
  int       n_vec = 0;
  int       n_err = 0;
  int       m_pc;

  program_sequencer #(
    .PC_W        (8),
    .TRACE_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .jmp         (jmp),
    .jmp_nz      (jmp_nz),
    .jmp_addr    (jmp_addr),
    .dont_jmp    (dont_jmp),
    .hold        (hold),
    .pm_addr     (pm_addr),
    .pc          (pc),
    .halted      (halted),
    .fetch_count (fetch_count),
    .trace_sel   (trace_sel),
    .trace_src   (trace_src),
    .trace_dst   (trace_dst),
    .trace_valid (trace_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] v);
    sb_item_t it;
    it.tag = tag;
    it.val = v;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_item_t it;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_underflow observed=%0h", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.val)
      else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", it.tag, obs, it.val);
      end
    end
  endtask

  initial begin
    reset = 1'b1; jmp = 1'b0; jmp_nz = 1'b0; jmp_addr = 4'h0;
    dont_jmp = 1'b0; hold = 1'b0; trace_sel = 2'd0;
    #2;
    push_exp("rst_pm", 0); chk(32'(pm_addr));
    push_exp("rst_pc", 0); chk(32'(pc));
    push_exp("rst_halted", 0); chk(32'(halted));
    push_exp("rst_valid", 0); chk(32'(trace_valid));
    push_exp("rst_count", 0); chk(32'(fetch_count));

    @(negedge clk); reset = 1'b0; #1;
    push_exp("release_pm", 1); chk(32'(pm_addr));

    // 300 sequential fetches, crossing the 0xFF -> 0x00 wrap
    m_pc = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      push_exp("seq_pm", (m_pc + 1) % 256); chk(32'(pm_addr));
      @(negedge clk);
      m_pc = (m_pc + 1) % 256;
    end
    #1;
    push_exp("seq_pc", 8'h2C); chk(32'(pc));
    push_exp("seq_count", 300); chk(32'(fetch_count));

    jmp = 1'b1; jmp_addr = 4'h0; #1;
    push_exp("jmp_2c_pm", 8'h20); chk(32'(pm_addr));
    @(negedge clk); jmp = 1'b0;
    jmp_nz = 1'b1; dont_jmp = 1'b1; jmp_addr = 4'h9; #1;
    push_exp("jnz_not_taken", 8'h21); chk(32'(pm_addr));
    @(negedge clk); dont_jmp = 1'b0; #1;
    push_exp("jnz_taken", 8'h29); chk(32'(pm_addr));
    @(negedge clk); jmp = 1'b1; dont_jmp = 1'b1; jmp_addr = 4'hF; #1;
    push_exp("jmp_and_jnz", 8'h2F); chk(32'(pm_addr));
    @(negedge clk); jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    #1;
    push_exp("walk_pc", 8'h37); chk(32'(pc));
    push_exp("walk_count", 312); chk(32'(fetch_count));

    jmp = 1'b1; jmp_addr = 4'hA; #1;
    push_exp("jmp_37_pm", 8'h3A); chk(32'(pm_addr));
    @(negedge clk); jmp = 1'b0; trace_sel = 2'd0; #1;
    push_exp("jmp_37_pc", 8'h3A); chk(32'(pc));
    push_exp("tr0_src", 8'h37); chk(32'(trace_src));
    push_exp("tr0_dst", 8'h3A); chk(32'(trace_dst));
    push_exp("tr0_valid", 1); chk(32'(trace_valid));
    trace_sel = 2'd3; #1;
    push_exp("tr3_src", 8'h2C); chk(32'(trace_src));
    push_exp("tr3_dst", 8'h20); chk(32'(trace_dst));

    reset = 1'b1; #1;
    push_exp("midrun_rst_pc", 0); chk(32'(pc));
    push_exp("midrun_rst_pm", 0); chk(32'(pm_addr));
    push_exp("midrun_rst_valid", 0); chk(32'(trace_valid));
    @(negedge clk); reset = 1'b0; trace_sel = 2'd0;
    for (int i = 0; i < 16; i++) @(negedge clk);
    #1;
    push_exp("pre_hold_pc", 8'h10); chk(32'(pc));

    hold = 1'b1; jmp = 1'b1; jmp_addr = 4'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      push_exp("hold_pm", 8'h10); chk(32'(pm_addr));
      push_exp("hold_count", 16); chk(32'(fetch_count));
      push_exp("hold_no_trace", 0); chk(32'(trace_valid));
      @(negedge clk);
    end
    hold = 1'b0; #1;
    push_exp("unhold_pm", 8'h15); chk(32'(pm_addr));
    @(negedge clk); jmp = 1'b0; #1;
    push_exp("unhold_pc", 8'h15); chk(32'(pc));
    push_exp("unhold_count", 17); chk(32'(fetch_count));
    push_exp("unhold_src", 8'h10); chk(32'(trace_src));
    push_exp("unhold_dst", 8'h15); chk(32'(trace_dst));

    for (int i = 0; i < 48; i++) @(negedge clk);
    jmp = 1'b1; jmp_addr = 4'h5; #1;
    push_exp("self_pm", 8'h45); chk(32'(pm_addr));
    push_exp("self_not_yet_halted", 0); chk(32'(halted));
    @(negedge clk); #1;
    push_exp("halted", 1); chk(32'(halted));
    push_exp("halt_pc", 8'h45); chk(32'(pc));
    push_exp("halt_count", 65); chk(32'(fetch_count));
    jmp_addr = 4'hA; jmp_nz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hold = (i == 1); #1;
      push_exp("halt_stuck_pm", 8'h45); chk(32'(pm_addr));
      @(negedge clk);
    end
    #1;
    push_exp("halt_count_frozen", 65); chk(32'(fetch_count));
    trace_sel = 2'd1; #1;
    push_exp("halt_no_trace", 0); chk(32'(trace_valid));

    #1; reset = 1'b1; #1;
    push_exp("halt_rst_pc", 0); chk(32'(pc));
    push_exp("halt_rst_halted", 0); chk(32'(halted));
    push_exp("halt_rst_pm", 0); chk(32'(pm_addr));
    for (int s = 0; s < 4; s++) begin
      trace_sel = 2'(s); #1;
      push_exp("rst_sel_valid", 0); chk(32'(trace_valid));
    end
    @(negedge clk); reset = 1'b0; jmp = 1'b0; jmp_nz = 1'b0; hold = 1'b0;
    trace_sel = 2'd0;

    // Six taken branches 0->2->4->...->C; the last one also reads sel 0
    jmp = 1'b1;
    for (int k = 0; k < 6; k++) begin
      jmp_addr = 4'(2 * (k + 1)); #1;
      push_exp("br6_pm", 2 * (k + 1)); chk(32'(pm_addr));
      if (k == 5) begin
        push_exp("rdw_src_prewrite", 8'h08); chk(32'(trace_src));
        push_exp("rdw_dst_prewrite", 8'h0A); chk(32'(trace_dst));
      end
      @(negedge clk);
    end
    jmp = 1'b0;
    for (int s = 0; s < 4; s++) begin
      trace_sel = 2'(s); #1;
      push_exp("br6_src", 8'h0A - 2 * s); chk(32'(trace_src));
      push_exp("br6_dst", 8'h0C - 2 * s); chk(32'(trace_dst));
      push_exp("br6_valid", 1); chk(32'(trace_valid));
    end
    push_exp("br6_count", 6); chk(32'(fetch_count));
    push_exp("br6_next_pm", 8'h0D); chk(32'(pm_addr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
